irq_encoder_ctrl: RTL and testbench
===================================

IRQ_ENCODER_CTRL -- requirements
Module: irq_encoder_ctrl

Interface
REQ-001 The block SHALL have one parameter, PRIO_LSB, default 1: 1 = din[0] highest priority; 0 = din[7] highest priority.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Reset; synchronous and active-high.
REQ-004 en  input  1  Enable; gates request capture and new grants.
REQ-005 din  input  8  Raw request lines; each bit is level, edge-detected internally.
REQ-006 mask  input  8  Per-line mask; 1 = line blocked from grant, still captured.
REQ-007 ack  input  1  Consumer acknowledge of the current grant.
REQ-008 dout  output  3  Registered binary index of the granted line.
REQ-009 valid  output  1  Registered; high while dout holds a grant awaiting ack.
REQ-010 pending  output  8  Registered latched-request vector.

Function
REQ-011 The block SHALL keep din_q, a registered copy of din, updated every cycle regardless of en.
REQ-012 When en=1 and din[i]=1 and din_q[i]=0 at an edge, the block SHALL set pending[i] at that edge.
REQ-013 When en=0, the block SHALL not set any pending bit, and existing pending bits SHALL be retained.
REQ-014 The FSM SHALL have exactly two states, IDLE and HOLD.
REQ-015 IDLE->HOLD: at an edge with en=1 and (pending & ~mask) != 0, the block SHALL load dout with the priority-selected index, set valid=1 and enter HOLD.
REQ-016 The pending value used by REQ-015 SHALL be the registered value before that edge, so a new edge reaches valid at the earliest one cycle after pending sets.
REQ-017 Priority selection SHALL pick the lowest set index when PRIO_LSB=1 and the highest set index when PRIO_LSB=0.
REQ-018 In HOLD, dout and valid SHALL stay stable; changes to mask, en or din SHALL not alter them.
REQ-019 HOLD->IDLE: at an edge with ack=1, the block SHALL clear pending[dout], set valid=0 and return to IDLE.
REQ-020 After an ack, the next grant SHALL occur no earlier than the following edge (minimum one idle cycle between grants).
REQ-021 ack SHALL be ignored in IDLE.
REQ-022 If a rising edge on line i and the ack clearing pending[i] occur at the same edge, the set SHALL win and pending[i] SHALL remain 1.
REQ-023 A line that re-pulses while already pending SHALL not be counted twice; pending is one bit per line.
REQ-024 With all pending lines masked, the block SHALL stay in IDLE with valid=0; unmasking SHALL grant at the next edge.
REQ-025 In IDLE, dout SHALL hold its last value; it is meaningful only while valid=1.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set state=IDLE, valid=0, dout=3'd0, pending=8'h00 and din_q=8'h00, overriding all other inputs.
REQ-027 Reset asserted in HOLD SHALL drop the grant without requiring ack.
REQ-028 A din bit held high across reset release SHALL be captured as a rising edge at the first edge after release (din_q resets to 0), provided en=1.

Verification
REQ-029 Reset: rst=1 for 2 cycles with din=8'hFF and en=1 -> valid=0, dout=0, pending=8'h00; after release, pending=8'hFF at the next edge and valid=1 with dout=0 one edge later.
REQ-030 Priority: PRIO_LSB=1, en=1, mask=0, pulse din=8'b1001_0100 -> grants in order dout=2, 4, 7, each held until ack, with one idle cycle between grants; repeat with PRIO_LSB=0 -> order 7, 4, 2.
REQ-031 Mask: pending=8'h08 and mask=8'h08 -> valid stays 0 for 5 cycles; clear mask -> valid=1 with dout=3 at the next edge.
REQ-032 Collision: in HOLD with dout=5, pulse a rising edge on din[5] at the same edge as ack -> valid=0 and pending[5]=1, then re-grant of dout=5 one edge later.
REQ-033 Enable: en=0, pulse din=8'h01 -> pending stays 8'h00 and valid=0; en=1 with din already high -> no capture until din falls and rises again.
REQ-034 Reset mid-grant: in HOLD with dout=6, assert rst for 1 cycle -> valid=0, pending=8'h00 and state IDLE, with no ack required.

Source files
------------

// File: rtl/irq_encoder_ctrl.sv
// Interrupt request encoder: edge-captures 8 request lines into a pending
// vector and grants one line at a time by fixed priority until acknowledged.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   en       - enables request capture and new grants
//   din[7:0] - raw level request lines (rising edges are latched)
//   mask     - 1 blocks a line from being granted (it is still latched)
//   ack      - consumer acknowledge of the current grant
//   dout     - registered index of the granted line
//   valid    - registered, high while a grant awaits ack
//   pending  - registered latched-request vector
module irq_encoder_ctrl #(
    parameter bit PRIO_LSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] din,
    input  logic [7:0] mask,
    input  logic       ack,
    output logic [2:0] dout,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] din_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] dout_q, dout_d;
    logic       valid_q, valid_d;

    logic [7:0] elig;
    logic       grant;
    logic [2:0] pick;

    // Grants look at the pending value from before this edge, so a fresh
    // request needs one cycle in pending before it can be granted.
    assign elig  = pending_q & ~mask;
    assign grant = en && (elig != 8'h00);

    always_comb begin
        pick = 3'd0;
        if (PRIO_LSB) begin
            for (int i = 7; i >= 0; i--) begin
                if (elig[i]) pick = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) pick = 3'(i);
            end
        end
    end

    // Ack clears the granted bit first; a simultaneous new edge re-sets it.
    always_comb begin
        pending_d = pending_q;
        if (state_q == HOLD && ack) pending_d[dout_q] = 1'b0;
        if (en) pending_d = pending_d | (din & ~din_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            din_q     <= 8'h00;
            pending_q <= 8'h00;
            dout_q    <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din;
            pending_q <= pending_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant) state_d = HOLD;
            HOLD: if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    dout_d  = pick;
                    valid_d = 1'b1;
                end
            end
            HOLD: if (ack) valid_d = 1'b0;
            default: valid_d = 1'b0;
        endcase
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_encoder_ctrl.sv
// Scoreboard bench for irq_encoder_ctrl: both priority orders driven with
// directed and random stimulus, checked against a behavioural model.
module tb_irq_encoder_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, ack;
    logic [7:0] din, mask;
    logic [2:0] dout1, dout0;
    logic       valid1, valid0;
    logic [7:0] pend1, pend0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_encoder_ctrl #(.PRIO_LSB(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .mask(mask), .ack(ack),
        .dout(dout1), .valid(valid1), .pending(pend1)
    );

    irq_encoder_ctrl #(.PRIO_LSB(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .mask(mask), .ack(ack),
        .dout(dout0), .valid(valid0), .pending(pend0)
    );

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic [7:0] p;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    // Behavioural model: one request flag per line, a granted flag and the
    // granted line number; k=1 favours low lines, k=0 favours high lines.
    bit m_prev[8];
    bit m_pend[2][8];
    bit m_hold[2];
    int m_g[2];

    task automatic model_edge(input bit r, input bit e, input logic [7:0] d,
                              input logic [7:0] m, input bit a);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < 8; i++) m_pend[k][i] = 0;
                m_hold[k] = 0;
                m_g[k]    = 0;
            end else begin
                bit np[8];
                np = m_pend[k];
                if (m_hold[k] && a) np[m_g[k]] = 0;
                if (e) begin
                    for (int i = 0; i < 8; i++)
                        if (d[i] && !m_prev[i]) np[i] = 1;
                end
                if (m_hold[k]) begin
                    if (a) m_hold[k] = 0;
                end else if (e) begin
                    int best = -1;
                    for (int j = 0; j < 8; j++) begin
                        int idx = (k == 1) ? j : 7 - j;
                        if (best < 0 && m_pend[k][idx] && !m[idx]) best = idx;
                    end
                    if (best >= 0) begin
                        m_hold[k] = 1;
                        m_g[k]    = best;
                    end
                end
                m_pend[k] = np;
            end
        end
        for (int i = 0; i < 8; i++) m_prev[i] = r ? 1'b0 : d[i];
        for (int k = 0; k < 2; k++) begin
            exp_t x;
            x.v = m_hold[k];
            x.d = 3'(m_g[k]);
            for (int i = 0; i < 8; i++) x.p[i] = m_pend[k][i];
            if (k == 1) q1.push_back(x);
            else q0.push_back(x);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input logic [7:0] d,
                       input logic [7:0] m, input bit a);
        @(negedge clk);
        rst  = r;
        en   = e;
        din  = d;
        mask = m;
        ack  = a;
        model_edge(r, e, d, m, a);
    endtask

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                exp_t x;
                x = q1.pop_front();
                check("lsb_valid", {7'd0, valid1}, {7'd0, x.v});
                check("lsb_dout", {5'd0, dout1}, {5'd0, x.d});
                check("lsb_pending", pend1, x.p);
            end
            if (q0.size() > 0) begin
                exp_t x;
                x = q0.pop_front();
                check("msb_valid", {7'd0, valid0}, {7'd0, x.v});
                check("msb_dout", {5'd0, dout0}, {5'd0, x.d});
                check("msb_pending", pend0, x.p);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        din  = 8'h00;
        mask = 8'h00;
        ack  = 1'b0;

        // reset with all lines high, then release
        cyc(1, 1, 8'hFF, 8'h00, 0);
        cyc(1, 1, 8'hFF, 8'h00, 0);
        cyc(0, 1, 8'hFF, 8'h00, 0);
        cyc(0, 1, 8'hFF, 8'h00, 0);
        cyc(0, 1, 8'hFF, 8'h00, 0);
        cyc(1, 1, 8'h00, 8'h00, 0);

        // priority ordering, continuous ack
        cyc(0, 1, 8'h94, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 8'h00, 1);

        // masked pending line, then unmask
        cyc(0, 1, 8'h08, 8'h08, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 8'h08, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 1);
        cyc(0, 1, 8'h00, 8'h00, 0);

        // collision of ack and new edge on the granted line
        cyc(0, 1, 8'h20, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h20, 8'h00, 1);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 1);
        cyc(0, 1, 8'h00, 8'h00, 0);

        // enable gating
        cyc(0, 0, 8'h01, 8'h00, 0);
        cyc(0, 0, 8'h00, 8'h00, 0);
        cyc(0, 0, 8'h01, 8'h00, 0);
        cyc(0, 1, 8'h01, 8'h00, 0);
        cyc(0, 1, 8'h01, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h01, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 1);
        cyc(0, 1, 8'h00, 8'h00, 0);

        // reset during a grant
        cyc(0, 1, 8'h40, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);
        cyc(1, 1, 8'h00, 8'h00, 0);
        cyc(0, 1, 8'h00, 8'h00, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit r, e, a;
            logic [7:0] d, m;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) < 8);
            a = ($urandom_range(0, 2) == 0);
            d = 8'($urandom());
            m = 8'($urandom()) & 8'($urandom());
            cyc(r, e, d, m, a);
        end

        repeat (3) @(posedge clk);
        #2;
        if (q1.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d/%0d required=0/0", q1.size(), q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
